nv_nvdla_sdp_mrdma_eg_cmd: RTL and testbench

Egress-side consumer of the SDP MRDMA context queue. It pops 14-bit read-command descriptors that the ingress side pushed into the queue. It counts the matching DMA read-response beats against each descriptor and forwards the data to the SDP datapath, tagged with line, surface and cube end flags. It also raises a one-cycle done pulse when the cube-end command completes.

---
 rtl/sdp_mrdma_pkg.sv | 32 +++
 rtl/nv_nvdla_sdp_mrdma_eg_pipe.sv | 34 +++
 rtl/nv_nvdla_sdp_mrdma_eg_cmd.sv | 146 ++++++++++++++
 tb/tb_nv_nvdla_sdp_mrdma_eg_cmd.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdp_mrdma_pkg.sv
// Shared definitions for the SDP MRDMA egress command path: descriptor
// field layout and the egress FSM state encoding.
package sdp_mrdma_pkg;

    localparam int CQ_PD_W      = 14;
    localparam int NBEAT_LSB    = 0;
    localparam int NBEAT_MSB    = 10;
    localparam int LINE_END_BIT = 11;
    localparam int SURF_END_BIT = 12;
    localparam int CUBE_END_BIT = 13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } eg_state_e;

    // Field order mirrors the context-queue payload bit positions above.
    typedef struct packed {
        logic                         cube_end;
        logic                         surf_end;
        logic                         line_end;
        logic [NBEAT_MSB-NBEAT_LSB:0] nbeat_m1;
    } eg_cmd_t;

    // Flags as they appear in the top bits of the datapath payload.
    function automatic logic [2:0] cmd_flags(input eg_cmd_t c);
        return {c.cube_end, c.surf_end, c.line_end};
    endfunction

endpackage

// File: rtl/nv_nvdla_sdp_mrdma_eg_pipe.sv
// Single-entry valid/ready output register for the egress datapath.
// Payload only updates on an accepted input, so it is stable under stall.
module nv_nvdla_sdp_mrdma_eg_pipe #(
    parameter int W = 67
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         in_vld_i,
    output logic         in_rdy_o,
    input  logic [W-1:0] in_pd_i,
    output logic         out_vld_o,
    input  logic         out_rdy_i,
    output logic [W-1:0] out_pd_o
);

    logic         vld_q;
    logic [W-1:0] pd_q;

    assign in_rdy_o  = !vld_q || out_rdy_i;
    assign out_vld_o = vld_q;
    assign out_pd_o  = pd_q;

    // Hold the beat until the consumer takes it; refill in the same cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_q <= 1'b0;
            pd_q  <= '0;
        end else begin
            if (in_rdy_o) vld_q <= in_vld_i;
            if (in_vld_i && in_rdy_o) pd_q <= in_pd_i;
        end
    end

endmodule

// File: rtl/nv_nvdla_sdp_mrdma_eg_cmd.sv
// SDP MRDMA egress command consumer: pops read descriptors, counts DMA
// response beats against them and forwards data tagged with end flags.
// Optional stall counter: define NV_NVDLA_SDP_MRDMA_EG_PERF_EN.
module nv_nvdla_sdp_mrdma_eg_cmd
    import sdp_mrdma_pkg::*;
#(
    parameter int DW     = 64,
    parameter int BEAT_W = 11
) (
    input  logic                nvdla_core_clk,
    input  logic                nvdla_core_rstn,
    input  logic                op_load,
    input  logic                cq2eg_pvld,
    output logic                cq2eg_prdy,
    input  logic [CQ_PD_W-1:0]  cq2eg_pd,
    input  logic                dma_rd_rsp_pvld,
    output logic                dma_rd_rsp_prdy,
    input  logic [DW-1:0]       dma_rd_rsp_pd,
    output logic                eg2dp_pvld,
    input  logic                eg2dp_prdy,
    output logic [DW+2:0]       eg2dp_pd,
    output logic                eg_done,
    output logic                eg_busy,
    output logic [31:0]         perf_stall_cnt
);

    eg_state_e         state_q, state_d;
    eg_cmd_t           cmd_q, cmd_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic              busy_q, done_q, done_d;

    eg_cmd_t           cq_cmd;
    logic              xfer_vld, pipe_in_rdy, dma_acc, last_beat, drained;
    logic [DW+2:0]     pipe_in_pd;

    assign cq_cmd    = eg_cmd_t'(cq2eg_pd);
    assign xfer_vld  = (state_q == ST_XFER) && dma_rd_rsp_pvld;
    assign dma_acc   = xfer_vld && pipe_in_rdy;
    assign last_beat = dma_acc && (beat_cnt_q == BEAT_W'(cmd_q.nbeat_m1));
    assign drained   = !eg2dp_pvld || eg2dp_prdy;
    // Flags ride only on the final beat of a command.
    assign pipe_in_pd = {last_beat ? cmd_flags(cmd_q) : 3'b000, dma_rd_rsp_pd};
    assign done_d     = (state_q == ST_DONE) && drained;

    // FSM state, held descriptor and beat counter.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q    <= ST_IDLE;
            cmd_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Next state: a non-cube last beat may chain straight into the next descriptor.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        beat_cnt_d = beat_cnt_q;
        unique case (state_q)
            ST_IDLE: if (op_load) state_d = ST_CMD;
            ST_CMD: begin
                if (cq2eg_pvld) begin
                    cmd_d      = cq_cmd;
                    beat_cnt_d = '0;
                    state_d    = ST_XFER;
                end
            end
            ST_XFER: begin
                if (last_beat) begin
                    if (cmd_q.cube_end) begin
                        state_d = ST_DONE;
                    end else if (cq2eg_pvld) begin
                        cmd_d      = cq_cmd;
                        beat_cnt_d = '0;
                    end else begin
                        state_d = ST_CMD;
                    end
                end else if (dma_acc) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            ST_DONE: if (drained) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        cq2eg_prdy      = 1'b0;
        dma_rd_rsp_prdy = 1'b0;
        unique case (state_q)
            ST_CMD:  cq2eg_prdy = 1'b1;
            ST_XFER: begin
                dma_rd_rsp_prdy = pipe_in_rdy;
                cq2eg_prdy      = last_beat && !cmd_q.cube_end;
            end
            default: ;
        endcase
    end

    // Layer status: busy from the cycle after op_load until the done pulse.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
            if (done_d)                            busy_q <= 1'b0;
            else if (state_q == ST_IDLE && op_load) busy_q <= 1'b1;
        end
    end

    assign eg_done = done_q;
    assign eg_busy = busy_q;

    nv_nvdla_sdp_mrdma_eg_pipe #(.W(DW+3)) u_pipe (
        .clk_i     (nvdla_core_clk),
        .rst_n_i   (nvdla_core_rstn),
        .in_vld_i  (xfer_vld),
        .in_rdy_o  (pipe_in_rdy),
        .in_pd_i   (pipe_in_pd),
        .out_vld_o (eg2dp_pvld),
        .out_rdy_i (eg2dp_prdy),
        .out_pd_o  (eg2dp_pd)
    );

`ifdef NV_NVDLA_SDP_MRDMA_EG_PERF_EN
    logic [31:0] stall_cnt_q;

    // Saturating count of cycles the datapath refuses a held beat.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn)                                      stall_cnt_q <= '0;
        else if (op_load)                                          stall_cnt_q <= '0;
        else if (eg2dp_pvld && !eg2dp_prdy && stall_cnt_q != '1)   stall_cnt_q <= stall_cnt_q + 1'b1;
    end

    assign perf_stall_cnt = stall_cnt_q;
`else
    assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_nv_nvdla_sdp_mrdma_eg_cmd.sv
// Randomized self-checking bench for nv_nvdla_sdp_mrdma_eg_cmd.
module tb_nv_nvdla_sdp_mrdma_eg_cmd;

    localparam int DW = 64;
    localparam int PW = DW + 3;

    logic          clk = 1'b0, rstn = 1'b0, op_load = 1'b0;
    logic          cq_pvld = 1'b0, dma_pvld = 1'b0, out_prdy = 1'b0;
    logic [13:0]   cq_pd = '0;
    logic [DW-1:0] dma_pd = '0;
    logic          cq_prdy, dma_prdy, out_pvld, eg_done, eg_busy;
    logic [PW-1:0] out_pd;
    logic [31:0]   perf;

    nv_nvdla_sdp_mrdma_eg_cmd #(.DW(DW), .BEAT_W(11)) dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .op_load         (op_load),
        .cq2eg_pvld      (cq_pvld),
        .cq2eg_prdy      (cq_prdy),
        .cq2eg_pd        (cq_pd),
        .dma_rd_rsp_pvld (dma_pvld),
        .dma_rd_rsp_prdy (dma_prdy),
        .dma_rd_rsp_pd   (dma_pd),
        .eg2dp_pvld      (out_pvld),
        .eg2dp_prdy      (out_prdy),
        .eg2dp_pd        (out_pd),
        .eg_done         (eg_done),
        .eg_busy         (eg_busy),
        .perf_stall_cnt  (perf)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Stimulus sources and reference stream
    logic [13:0]   plan[$];
    logic [13:0]   desc_q[$];
    logic [DW-1:0] dma_q[$];
    logic [PW-1:0] exp_q[$];
    int cq_rate = 100, dma_rate = 100, out_rate = 100, cq_gap = 0, stall_req = 0, cq_hold = 0;
    bit cq_hs, dma_hs, out_hs;

    // Source/sink drivers: valid holds until taken, ready is random or forced low.
    initial forever begin
        logic [13:0]   dtmp;
        logic [DW-1:0] btmp;
        @(posedge clk); #1;
        if (!rstn) begin
            cq_pvld = 0; dma_pvld = 0; out_prdy = 0; cq_hold = 0;
        end else begin
            if (cq_hs) begin
                if (desc_q.size() > 0) dtmp = desc_q.pop_front();
                cq_pvld = 0;
                cq_hold = cq_gap;
            end
            if (!cq_pvld) begin
                if (cq_hold > 0) cq_hold--;
                else if (desc_q.size() > 0 && $urandom_range(1, 100) <= cq_rate) begin
                    cq_pvld = 1; cq_pd = desc_q[0];
                end
            end
            if (dma_hs) begin
                if (dma_q.size() > 0) btmp = dma_q.pop_front();
                dma_pvld = 0;
            end
            if (!dma_pvld && dma_q.size() > 0 && $urandom_range(1, 100) <= dma_rate) begin
                dma_pvld = 1; dma_pd = dma_q[0];
            end
            if (stall_req > 0) begin
                out_prdy = 0; stall_req--;
            end else begin
                out_prdy = ($urandom_range(1, 100) <= out_rate);
            end
        end
    end

    // Reference model state (what the outputs must be, from the behavioural rules)
    int budget = 0;               // beats still owed to accepted descriptors
    bit cube_seen = 0, busy_exp = 0, done_exp = 0;
    logic [31:0] perf_exp = 0;
    bit prev_dma_hs = 0, prev_stall = 0;
    logic [DW-1:0] prev_dma_d;
    logic [PW-1:0] prev_pd;
    int outs_seen = 0, flagged_seen = 0, done_seen = 0, cyc = 0, last_out_cyc = 0, done_cyc = 0;
    int cq_run = 0, max_cq_run = 0, out_run = 0, max_out_run = 0, cmd_wait = 0;

    always @(negedge clk) begin
        logic [PW-1:0] e;
        bit cube_beat;
        cyc++;
        if (!rstn) begin
            budget = 0; cube_seen = 0; busy_exp = 0; done_exp = 0; perf_exp = 0;
            prev_dma_hs = 0; prev_stall = 0; cq_hs = 0; dma_hs = 0; out_hs = 0;
        end else begin
            cq_hs  = cq_pvld && cq_prdy;
            dma_hs = dma_pvld && dma_prdy;
            out_hs = out_pvld && out_prdy;
            cube_beat = 0;
            chk("busy", eg_busy, busy_exp);
            chk("done", eg_done, done_exp);
            if (eg_done) begin done_seen++; done_cyc = cyc; end
            chk("perf", perf, perf_exp);
            chk("dma_prdy", dma_prdy, (budget > 0) && !(out_pvld && !out_prdy));
            chk("cq_prdy", cq_prdy, busy_exp && !cube_seen && (budget == 0 || (budget == 1 && dma_hs)));
            if (prev_dma_hs) begin
                chk("lat_vld", out_pvld, 1'b1);
                chk("lat_data", out_pd[DW-1:0], prev_dma_d);
            end
            if (prev_stall) begin
                chk("stall_vld", out_pvld, 1'b1);
                chk("stall_pd", out_pd, prev_pd);
            end
            if (out_hs) begin
                if (exp_q.size() == 0) fail_now("extra_beat");
                else begin
                    e = exp_q.pop_front();
                    chk("out_beat", out_pd, e);
                    cube_beat = e[PW-1];
                end
                outs_seen++;
                if (out_pd[PW-1:DW] != 3'b000) flagged_seen++;
                last_out_cyc = cyc;
            end
            if (busy_exp && !cube_seen && budget == 0) cmd_wait++;
            cq_run  = cq_hs ? cq_run + 1 : 0;
            out_run = out_hs ? out_run + 1 : 0;
            if (cq_run > max_cq_run) max_cq_run = cq_run;
            if (out_run > max_out_run) max_out_run = out_run;
            // advance the model to the next cycle
            done_exp = cube_beat;
            busy_exp = busy_exp ? !cube_beat : op_load;
            if (cube_beat) cube_seen = 0;
            if (cq_hs) begin
                budget += int'(cq_pd[10:0]) + 1;
                if (cq_pd[13]) cube_seen = 1;
            end
            if (dma_hs) budget--;
`ifdef NV_NVDLA_SDP_MRDMA_EG_PERF_EN
            if (op_load) perf_exp = 0;
            else if (out_pvld && !out_prdy && perf_exp != 32'hFFFF_FFFF) perf_exp = perf_exp + 1;
`endif
            prev_dma_hs = dma_hs; prev_dma_d = dma_pd;
            prev_stall = out_pvld && !out_prdy; prev_pd = out_pd;
        end
    end

    // Build the expected output stream from the plan, then pulse op_load.
    task automatic start_layer();
        logic [DW-1:0] d;
        int n;
        outs_seen = 0; flagged_seen = 0; max_cq_run = 0; max_out_run = 0; cmd_wait = 0;
        foreach (plan[i]) begin
            n = int'(plan[i][10:0]);
            for (int b = 0; b <= n; b++) begin
                d = {$urandom, $urandom};
                dma_q.push_back(d);
                exp_q.push_back({(b == n) ? plan[i][13:11] : 3'b000, d});
            end
            desc_q.push_back(plan[i]);
        end
        plan.delete();
        @(posedge clk); #1 op_load = 1;
        @(posedge clk); #1 op_load = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #2 rstn = 0;
        desc_q.delete(); dma_q.delete(); exp_q.delete();
        repeat (3) @(posedge clk);
        #2 rstn = 1;
    endtask

    task automatic wait_done(input string name, input int limit);
        int start = done_seen;
        int k = 0;
        while (done_seen == start && k < limit) begin @(negedge clk); #1; k++; end
        if (done_seen == start) begin
            fail_now({name, "_timeout"});
            do_reset();
        end
        chk({name, "_left"}, exp_q.size(), 0);
    endtask

    task automatic wait_outs(input string name, input int n);
        int k = 0;
        while (outs_seen < n && k < 500) begin @(negedge clk); #1; k++; end
        if (outs_seen < n) fail_now({name, "_outs_timeout"});
    endtask

    task automatic test_single(input string name);
        plan.push_back(14'h3803);
        start_layer();
        wait_done(name, 300);
        chk({name, "_beats"}, outs_seen, 4);
        chk({name, "_flagged"}, flagged_seen, 1);
        chk({name, "_done_lat"}, done_cyc - last_out_cyc, 1);
    endtask

    task automatic reset_outs_zero(input string name);
        chk({name, "_pvld"}, out_pvld, 0);
        chk({name, "_pd"}, out_pd, 0);
        chk({name, "_cq_prdy"}, cq_prdy, 0);
        chk({name, "_dma_prdy"}, dma_prdy, 0);
        chk({name, "_done"}, eg_done, 0);
        chk({name, "_busy"}, eg_busy, 0);
        chk({name, "_perf"}, perf, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [13:0] d;
        int nd, d0;
        repeat (3) @(posedge clk);
        #1 reset_outs_zero("rst");
        @(posedge clk); #2 rstn = 1;

        // 1: single 4-beat cube command
        test_single("t1");

        // 2: back-to-back single-beat descriptors
        plan.push_back(14'h0800); plan.push_back(14'h0800); plan.push_back(14'h3800);
        start_layer();
        wait_done("t2", 300);
        chk("t2_cq_run", max_cq_run, 3);
        chk("t2_out_run", max_out_run, 3);
        chk("t2_beats", outs_seen, 3);
        chk("t2_flagged", flagged_seen, 3);

        // 3: five-cycle output stall mid-command
        plan.push_back(14'h3807);
        start_layer();
        wait_outs("t3", 2);
        stall_req = 5;
        wait_done("t3", 300);
        chk("t3_beats", outs_seen, 8);
`ifdef NV_NVDLA_SDP_MRDMA_EG_PERF_EN
        chk("t3_perf", perf, 5);
`else
        chk("t3_perf", perf, 0);
`endif

        // 4: descriptor starvation between commands
        cq_gap = 10;
        plan.push_back(14'h0801); plan.push_back(14'h3801);
        start_layer();
        wait_done("t4", 300);
        cq_gap = 0;
        chk("t4_beats", outs_seen, 4);
        chk("t4_cmd_wait", cmd_wait >= 6, 1'b1);

        // 5: maximum-length command with random back-pressure
        dma_rate = 90; out_rate = 80;
        plan.push_back(14'h3FFF);
        start_layer();
        wait_done("t5", 20000);
        chk("t5_beats", outs_seen, 2048);
        chk("t5_flagged", flagged_seen, 1);

        // random layers
        for (int l = 0; l < 8; l++) begin
            cq_rate = $urandom_range(40, 100); dma_rate = $urandom_range(40, 100);
            out_rate = $urandom_range(40, 100);
            nd = $urandom_range(1, 5);
            if (l == 3) plan.push_back(14'h0007);
            for (int i = 0; i < nd; i++) begin
                d = '0;
                d[10:0] = ($urandom_range(0, 3) == 0) ? 11'd0 : 11'($urandom_range(0, 15));
                d[11] = 1'($urandom_range(0, 1));
                d[12] = 1'($urandom_range(0, 1));
                d[13] = (i == nd - 1);
                plan.push_back(d);
            end
            start_layer();
            if (l == 3) begin
                // ignored for FSM purposes, but clears the stall counter
                @(posedge clk); #1 op_load = 1;
                @(posedge clk); #1 op_load = 0;
            end
            wait_done("rnd", 3000);
        end

        // 6: reset mid-layer, then a clean rerun
        cq_rate = 100; dma_rate = 100; out_rate = 100;
        plan.push_back(14'h3803);
        start_layer();
        wait_outs("t6", 2);
        @(posedge clk); #2 rstn = 0;
        desc_q.delete(); dma_q.delete(); exp_q.delete();
        #1 reset_outs_zero("t6_rst");
        repeat (3) @(posedge clk);
        #2 rstn = 1;
        d0 = done_seen;
        repeat (10) @(negedge clk);
        chk("t6_no_done", done_seen, d0);
        test_single("t6_rerun");

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
